// File: rtl/debug_pkg.sv
// Shared types and width helpers for the debug-link blocks (UART TX arbiter,
// register-file access arbiter).
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCKED    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int unsigned UART_BYTE_W = 8;

  // Counter / index width for a range of n values; never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_idx,
// wrapping modulo N.
module rr_pick
  import debug_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = cnt_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N-1:0]     win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  int unsigned cand;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    cand       = 0;
    // Offsets 1..N from last_idx; offset N lands on last_idx itself (lowest priority).
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(last_idx) + k;
      if (cand >= N) cand = cand - N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!win_any && (cand == j) && req[j]) begin
          win_any       = 1'b1;
          win_idx       = IDX_W'(j);
          win_onehot[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-message arbiter sharing one UART transmitter between NUM_REQ byte
// streams; a grant is held until the byte flagged last has left the UART.
module uart_tx_arbiter
  import debug_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [UART_BYTE_W-1:0]        tx_data_o,
  output logic                          tx_start,
  input  logic                          busy,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          active_o,
  output logic                          timeout_err
);

  localparam int unsigned IDX_W  = cnt_w(NUM_REQ);
  localparam int unsigned LOCK_W = cnt_w(LOCK_TIMEOUT);
  localparam int unsigned ACK_W  = cnt_w(ACK_TIMEOUT);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (LOCK_TIMEOUT < 1 || ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: timeouts must be at least 1");
  end

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic                last_flag_q, last_flag_d;
  logic                timeout_q, timeout_d;

  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  byte_done;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_idx   (last_grant_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_any    (pick_any)
  );

  // Owner's handshake signals, muxed by the one-hot grant.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant_q[j]) begin
        own_valid = req_valid[j];
        own_last  = req_last[j];
        own_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    last_flag_d  = last_flag_q;
    timeout_d    = 1'b0;
    byte_done    = 1'b0;
    req_ready    = '0;
    tx_start     = 1'b0;
    tx_data_o    = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_onehot;
          owner_d    = pick_idx;
          lock_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        // A launch wins over a timeout expiring in the same cycle.
        if (own_valid && !busy) begin
          tx_start    = 1'b1;
          tx_data_o   = UART_BYTE_W'(own_data);
          req_ready   = grant_q;
          last_flag_d = own_last;
          ack_cnt_d   = '0;
          state_d     = WAIT_ACK;
        end else if (lock_cnt_q == LOCK_LAST) begin
          timeout_d    = 1'b1;
          last_grant_d = owner_q;
          grant_d      = '0;
          state_d      = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      WAIT_ACK: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          byte_done = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!busy) byte_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Shared exit for a completed byte (busy fell, or the ack wait expired).
    if (byte_done) begin
      if (last_flag_q) begin
        last_grant_d = owner_q;
        grant_d      = '0;
        state_d      = IDLE;
      end else begin
        lock_cnt_d = '0;
        state_d    = LOCKED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      lock_cnt_q   <= '0;
      ack_cnt_q    <= '0;
      last_flag_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      last_flag_q  <= last_flag_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant_o     = grant_q;
  assign active_o    = (state_q != IDLE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-fed requesters, a counting UART
// busy model and a log of launched bytes checked against hand-computed values.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data_o;
  logic        tx_start;
  logic        busy;
  logic [1:0]  grant_o;
  logic        active_o;
  logic        timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .DATA_WIDTH   (8),
    .LOCK_TIMEOUT (1024),
    .ACK_TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data_o   (tx_data_o),
    .tx_start    (tx_start),
    .busy        (busy),
    .grant_o     (grant_o),
    .active_o    (active_o),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] txd_q[$];
  int         start_q[$];
  logic [1:0] gnt_q[$];
  int         to_q[$];

  bit  busy_auto  = 1'b1;
  bit  busy_force = 1'b0;
  int  busy_len   = 10;
  int  busy_cnt   = 0;
  assign busy = busy_force || (busy_cnt != 0);

  logic [1:0] gnt_or;
  logic [1:0] rdy_or;
  int         idle_cyc;
  int         n;
  int         rel;

  logic [7:0] exp2 [8] = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hA1, 8'hA2, 8'hB1, 8'hB2};
  logic [1:0] expg2[8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
  logic [7:0] exp6 [5] = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hF1};
  logic [1:0] expg6[5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // UART model: busy for busy_len cycles after each accepted launch.
  always @(posedge clk) begin
    if (busy_auto && tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      txd_q.push_back(tx_data_o);
      start_q.push_back(cyc);
      gnt_q.push_back(grant_o);
    end
    if (timeout_err) to_q.push_back(cyc);
  end

  // Requesters: pop on handshake, re-present the queue head shortly after the edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (req_valid[0] && req_ready[0] && q0.size() != 0) void'(q0.pop_front());
      if (req_valid[1] && req_ready[1] && q1.size() != 0) void'(q1.pop_front());
    end
    #2;
    req_valid[0]   = (q0.size() != 0);
    req_last[0]    = (q0.size() != 0) ? q0[0][8]   : 1'b0;
    req_data[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    req_valid[1]   = (q1.size() != 0);
    req_last[1]    = (q1.size() != 0) ? q1[0][8]   : 1'b0;
    req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    txd_q.delete(); start_q.delete(); gnt_q.delete(); to_q.delete();
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1;
    #2;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k;
    k = 0;
    gnt_or = '0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || active_o) && k < budget) begin
      gnt_or |= grant_o;
      @(negedge clk);
      k++;
    end
    idle_cyc = cyc;
    chk({tag, "_idle"}, {31'd0, active_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant",  32'(grant_o), 0);
    chk("rst_active", 32'(active_o), 0);
    chk("rst_start",  32'(tx_start), 0);
    chk("rst_data",   32'(tx_data_o), 0);
    chk("rst_ready",  32'(req_ready), 0);
    chk("rst_tmo",    32'(timeout_err), 0);
    sync();
    rst = 1'b0;

    // 1: "\n>42" from req0, 12-cycle byte period with a 10-cycle busy
    clear_log();
    q0.push_back({1'b0, 8'h0A}); q0.push_back({1'b0, 8'h3E});
    q0.push_back({1'b0, 8'h34}); q0.push_back({1'b1, 8'h32});
    run_until_idle("t1", 200);
    chk("t1_count", txd_q.size(), 4);
    if (txd_q.size() == 4) begin
      chk("t1_b0", 32'(txd_q[0]), 32'h0A);
      chk("t1_b1", 32'(txd_q[1]), 32'h3E);
      chk("t1_b2", 32'(txd_q[2]), 32'h34);
      chk("t1_b3", 32'(txd_q[3]), 32'h32);
      for (int i = 1; i < 4; i++)
        chk($sformatf("t1_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 12);
      chk("t1_release", 32'(idle_cyc - start_q[3]), 12);
    end
    chk("t1_grant", 32'(gnt_or), 32'h1);

    // 2: both requesters valid out of reset, then again: messages alternate
    do_reset();
    clear_log();
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b0, 8'hB1}); q1.push_back({1'b1, 8'hB2});
    run_until_idle("t2a", 200);
    sync();
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b0, 8'hB1}); q1.push_back({1'b1, 8'hB2});
    run_until_idle("t2b", 200);
    chk("t2_count", txd_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < txd_q.size()) begin
        chk($sformatf("t2_byte%0d", i), 32'(txd_q[i]), 32'(exp2[i]));
        chk($sformatf("t2_gnt%0d", i),  32'(gnt_q[i]),  32'(expg2[i]));
      end
    end

    // 3: req1 stalls mid-message -> lock revoked, waiting req0 granted next
    do_reset();
    clear_log();
    q1.push_back({1'b0, 8'hC1});
    n = 0;
    while (q1.size() != 0 && n < 50) begin @(negedge clk); n++; end
    sync();
    q0.push_back({1'b1, 8'hD0});
    rdy_or = '0;
    n = 0;
    @(negedge clk);
    while (!timeout_err && n < 1200) begin
      rdy_or |= req_ready;
      @(negedge clk);
      n++;
    end
    chk("t3_tmo_seen", 32'(timeout_err), 1);
    if (start_q.size() != 0) chk("t3_tmo_cyc", 32'(cyc - start_q[0]), 1036);
    chk("t3_grant_clr", 32'(grant_o), 0);
    chk("t3_active",    32'(active_o), 0);
    chk("t3_rdy_other", 32'(rdy_or), 0);
    @(negedge clk);
    chk("t3_regrant",   32'(grant_o), 32'h1);
    chk("t3_tmo_pulse", 32'(timeout_err), 0);
    run_until_idle("t3", 100);
    chk("t3_count", txd_q.size(), 2);
    if (txd_q.size() == 2) chk("t3_b1", 32'(txd_q[1]), 32'hD0);
    chk("t3_tmo_n", to_q.size(), 1);

    // 4: busy never rises -> ack wait of 16 cycles, single launch
    sync();
    busy_auto = 1'b0;
    clear_log();
    q0.push_back({1'b1, 8'h55});
    run_until_idle("t4", 100);
    repeat (20) @(negedge clk);
    chk("t4_count", txd_q.size(), 1);
    if (txd_q.size() == 1) begin
      chk("t4_b0", 32'(txd_q[0]), 32'h55);
      chk("t4_release", 32'(idle_cyc - start_q[0]), 17);
    end

    // 5: UART busy while owner is LOCKED -> nothing consumed until busy falls
    sync();
    busy_auto  = 1'b1;
    busy_force = 1'b1;
    clear_log();
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h22});
    rdy_or = '0;
    repeat (30) begin @(negedge clk); rdy_or |= req_ready; end
    chk("t5_no_start", txd_q.size(), 0);
    chk("t5_no_ready", 32'(rdy_or), 0);
    chk("t5_active",   32'(active_o), 1);
    chk("t5_grant",    32'(grant_o), 32'h1);
    sync();
    busy_force = 1'b0;
    rel = cyc;
    run_until_idle("t5", 100);
    chk("t5_count", txd_q.size(), 2);
    if (txd_q.size() == 2) begin
      chk("t5_b0", 32'(txd_q[0]), 32'h11);
      chk("t5_b1", 32'(txd_q[1]), 32'h22);
      chk("t5_first", 32'(start_q[0] - rel), 0);
    end

    // 6: reset in WAIT_DONE of byte 2 -> outputs cleared, pointer back to req0
    sync();
    clear_log();
    q0.push_back({1'b0, 8'hE1}); q0.push_back({1'b0, 8'hE2});
    q0.push_back({1'b0, 8'hE3}); q0.push_back({1'b1, 8'hE4});
    n = 0;
    while (txd_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("t6_pre_active", 32'(active_o), 1);
    sync();
    rst = 1'b1;
    #2;
    chk("t6_grant",  32'(grant_o), 0);
    chk("t6_active", 32'(active_o), 0);
    chk("t6_start",  32'(tx_start), 0);
    chk("t6_data",   32'(tx_data_o), 0);
    chk("t6_ready",  32'(req_ready), 0);
    q0.delete();
    q1.delete();
    clear_log();
    q0.push_back({1'b0, 8'hE1}); q0.push_back({1'b0, 8'hE2});
    q0.push_back({1'b0, 8'hE3}); q0.push_back({1'b1, 8'hE4});
    q1.push_back({1'b1, 8'hF1});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_until_idle("t6", 300);
    chk("t6_count", txd_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < txd_q.size()) begin
        chk($sformatf("t6_byte%0d", i), 32'(txd_q[i]), 32'(exp6[i]));
        chk($sformatf("t6_gnt%0d", i),  32'(gnt_q[i]),  32'(expg6[i]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
